// File: rtl/count_slice_sched.sv
// Sequencer for a shared W-bit loadable up-counter slice arbitrated among NREQ requesters.
// Define COUNT_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module count_slice_sched #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] preload,
   input  logic              hold,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [W-1:0]      count,
   output logic              tc
);

   localparam int N = int'(NREQ);

   typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [W-1:0]    count_q, count_d;

   logic            win_valid;
   logic [NREQ-1:0] win_oh;
   logic [W-1:0]    win_load;
   logic            owner_req;

`ifdef COUNT_SCHED_RR_EN
   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] ptr_q, win_next;

   // Walk offsets from farthest to nearest so the nearest requester above ptr_q wins.
   always_comb begin
      win_valid = 1'b0;
      win_oh    = '0;
      win_load  = '0;
      win_next  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         for (int i = 0; i < N; i++) begin
            if (req[i] && (i == (int'(ptr_q) + k) % N)) begin
               win_valid = 1'b1;
               win_oh    = '0;
               win_oh[i] = 1'b1;
               win_load  = preload[i*W +: W];
               win_next  = (i == N - 1) ? '0 : PW'(i + 1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (state_q == StIdle && win_valid) begin
         ptr_q <= win_next;
      end
   end
`else
   always_comb begin
      win_valid = 1'b0;
      win_oh    = '0;
      win_load  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_valid = 1'b1;
            win_oh    = '0;
            win_oh[i] = 1'b1;
            win_load  = preload[i*W +: W];
         end
      end
   end
`endif

   always_comb begin
      owner_req = |(req & grant_q);
      tc        = (state_q == StCount) && (&count_q) && !hold;
      state_d   = state_q;
      grant_d   = grant_q;
      count_d   = count_q;
      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               state_d = StCount;
               grant_d = win_oh;
               count_d = win_load;
            end
         end
         StCount: begin
            // Abort wins over terminal count; hold never blocks an abort.
            if (!owner_req) begin
               state_d = StIdle;
               grant_d = '0;
            end else if (tc) begin
               state_d = StDone;
            end else if (!hold) begin
               count_d = count_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            grant_d = '0;
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         grant_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         count_q <= count_d;
      end
   end

   assign grant = grant_q;
   assign done  = (state_q == StDone) ? grant_q : '0;
   assign busy  = (state_q != StIdle);
   assign count = count_q;

endmodule

// File: tb/tb_count_slice_sched.sv
// Self-checking bench for count_slice_sched: directed scenarios then randomized traffic
// against a job-level reference model.
module tb_count_slice_sched;

   localparam int NREQ = 4;
   localparam int W    = 5;
   localparam int MAXC = (1 << W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] preload;
   logic              hold;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic [W-1:0]      count;
   logic              tc;

   int checks = 0;
   int errors = 0;

   // Reference model: which requester owns the job, its counter, whether it is reporting done.
   int m_owner;
   int m_cnt;
   int m_ptr;
   bit m_done;

   always #5 clk = ~clk;

   count_slice_sched #(.NREQ(NREQ), .W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .preload (preload),
      .hold    (hold),
      .grant   (grant),
      .done    (done),
      .busy    (busy),
      .count   (count),
      .tc      (tc)
   );

   function automatic void model_reset();
      m_owner = -1;
      m_cnt   = 0;
      m_ptr   = 0;
      m_done  = 1'b0;
   endfunction

   function automatic void model_edge();
      int w;
      w = -1;
      if (m_owner < 0) begin
`ifdef COUNT_SCHED_RR_EN
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
`else
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && req[k]) w = k;
`endif
         if (w >= 0) begin
            m_owner = w;
            m_cnt   = int'(preload[w*W +: W]);
            m_ptr   = (w + 1) % NREQ;
            m_done  = 1'b0;
         end
      end else if (m_done) begin
         m_owner = -1;
         m_done  = 1'b0;
      end else if (!req[m_owner]) begin
         m_owner = -1;
      end else if (!hold) begin
         if (m_cnt == MAXC) m_done = 1'b1;
         else m_cnt = m_cnt + 1;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [NREQ-1:0] eg;
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk({tag, " grant"}, 32'(grant), 32'(eg));
      chk({tag, " done"}, 32'(done), m_done ? 32'(eg) : 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'(m_owner >= 0));
      chk({tag, " count"}, 32'(count), 32'(m_cnt));
      chk({tag, " tc"}, 32'(tc),
          32'(m_owner >= 0 && !m_done && m_cnt == MAXC && !hold));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic set_pl(input int i, input int v);
      preload[i*W +: W] = W'(v);
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      #1;
      model_reset();
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int lat;
      int k;
      int prev;
      logic [NREQ-1:0] arb_exp [5];
`ifdef COUNT_SCHED_RR_EN
      arb_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
      arb_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
      rst     = 1'b1;
      req     = '0;
      preload = '0;
      hold    = 1'b0;
      #1;
      model_reset();
      check_all("init");
      chk("init count", 32'(count), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single job, preload 29.
      set_pl(0, 29);
      req = 4'b0001;
      step("t1");
      chk("t1 grant", 32'(grant), 32'h1);
      chk("t1 count", 32'(count), 32'd29);
      for (int n = 0; n < 10 && !m_done; n++) step("t1");
      chk("t1 done", 32'(done), 32'h1);
      req = '0;
      step("t1 end");
      chk("t1 idle", 32'(busy), 32'd0);

      // Hold stretch: two held cycles at count 30 add two cycles.
      set_pl(2, 30);
      req = 4'b0100;
      step("t2");
      lat  = 0;
      hold = 1'b1;
      step("t2 hold");
      chk("t2 held count", 32'(count), 32'd30);
      lat++;
      step("t2 hold");
      lat++;
      hold = 1'b0;
      for (int n = 0; n < 10 && !m_done; n++) begin
         step("t2");
         lat++;
      end
      chk("t2 latency", 32'(lat), 32'd4);
      chk("t2 done", 32'(done), 32'h4);
      req = '0;
      step("t2 end");

      // Preload all-ones: terminal count in the first COUNT cycle.
      set_pl(1, 31);
      req = 4'b0010;
      step("t3");
      chk("t3 tc", 32'(tc), 32'd1);
      step("t3");
      chk("t3 done", 32'(done), 32'h2);
      req = '0;
      step("t3 end");

      // Arbitration with all requesters held.
      reset_pulse();
      for (int i = 0; i < NREQ; i++) set_pl(i, 30);
      req = 4'b1111;
      k   = 0;
      for (int n = 0; n < 80 && k < 5; n++) begin
         prev = m_owner;
         step("arb");
         if (prev < 0 && m_owner >= 0) begin
            chk("arb grant", 32'(grant), 32'(arb_exp[k]));
            k++;
         end
      end
      chk("arb jobs", 32'(k), 32'd5);
      req = '0;
      for (int n = 0; n < 10 && m_owner >= 0; n++) step("arb drain");

      // Abort at count 10.
      set_pl(3, 8);
      req = 4'b1000;
      step("ab1");
      for (int n = 0; n < 10 && m_cnt != 10; n++) step("ab1");
      chk("ab1 count", 32'(count), 32'd10);
      req = '0;
      step("ab1 drop");
      chk("ab1 busy", 32'(busy), 32'd0);
      chk("ab1 retained", 32'(count), 32'd10);
      chk("ab1 done", 32'(done), 32'd0);

      // Abort on the terminal-count cycle.
      set_pl(3, 30);
      req = 4'b1000;
      step("ab2");
      step("ab2");
      chk("ab2 tc", 32'(tc), 32'd1);
      req = '0;
      step("ab2 drop");
      chk("ab2 done", 32'(done), 32'd0);
      chk("ab2 busy", 32'(busy), 32'd0);

      // Asynchronous reset mid-COUNT.
      set_pl(0, 0);
      req = 4'b0001;
      step("ar");
      step("ar");
      step("ar");
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("ar async");
      chk("ar busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step("ar regrant");
      chk("ar grant", 32'(grant), 32'h1);
      req = '0;
      for (int n = 0; n < 10 && m_owner >= 0; n++) step("ar drain");

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(0, 31) == 0) req[i] = ~req[i];
         for (int i = 0; i < NREQ; i++) set_pl(i, int'($urandom_range(0, MAXC)));
         hold = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 399) == 0) begin
            rst = 1'b1;
            #1;
            model_reset();
            check_all("rand rst");
            rst = 1'b0;
         end
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
